// File: rtl/rv32i_pkg.sv
// rv32i_pkg -- shared RV32I front-end definitions.
//
// Holds the fetch-unit parameter defaults (reset PC, fetch buffer depth),
// the instruction width and the sequential PC increment, plus a small
// helper for PC + 4 arithmetic.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When it is defined, the
// fetch FSM state type (FETCH/HALT) is provided here. Without it the fetch
// unit has no FSM and no state type is declared.

package rv32i_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned INSTR_W           = 32;
    localparam logic [31:0] PC_INC            = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam int unsigned BUF_DEPTH_DEFAULT = 2;

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;
`endif

    // Sequential PC step; wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo -- small circular buffer of fetched {pc, instr} entries.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   flush              synchronous clear (pointers and occupancy to zero)
//   push, push_data    write one 64-bit {pc, instr} entry
//   pop                release the head entry
//   head_data          current head entry (reset value RST_ENTRY)
//   empty              no valid entries
//   count              occupancy, 0..DEPTH
//
// Push when full and pop when empty are ignored; the fetch unit's credit
// scheme keeps the buffer from ever being asked to overflow.

module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH     = BUF_DEPTH_DEFAULT,
    parameter logic [63:0] RST_ENTRY = 64'h0,
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          push,
    input  logic [63:0]   push_data,
    input  logic          pop,
    output logic [63:0]   head_data,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PW'(i)] <= RST_ENTRY;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit -- RV32I instruction fetch stage.
//
// Issues sequential instruction-memory reads, collects in-order responses
// into a small {pc, instr} buffer and presents the buffer head to the IF/DE
// register. A redirect reloads both PCs, flushes the buffer and arranges
// for every response still in flight to be dropped.
//
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   i_Redirect, i_RedirectPC_32   branch/jump redirect and its target
//   o_IMemReq, o_IMemAddr_32      memory read request and address
//   i_IMemGnt                     request accepted this cycle
//   i_IMemRspValid, i_IMemRdata_32 in-order read response
//   o_Valid, i_Ready              head handshake toward IF/DE
//   o_NextPC_32, o_PCPlus4_32     head PC and head PC + 4
//   o_Instr_32                    head instruction word
//   o_MisalignErr                 sticky misaligned-redirect flag
//
// Handshakes: a request transfers on a cycle where o_IMemReq && i_IMemGnt;
// o_IMemReq does not depend on i_IMemGnt and o_IMemAddr_32 is held while a
// request waits. The head transfers on o_Valid && i_Ready; o_Valid does not
// depend on i_Ready.
//
// Macro FETCH_MISALIGN_CHECK_EN: when defined, a redirect whose target has
// nonzero bits [1:0] sets o_MisalignErr and parks the unit in HALT until
// reset. When undefined, target bits [1:0] are cleared and o_MisalignErr
// is tied low.

module if_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_Redirect,
    input  logic [31:0] i_RedirectPC_32,
    output logic        o_IMemReq,
    output logic [31:0] o_IMemAddr_32,
    input  logic        i_IMemGnt,
    input  logic        i_IMemRspValid,
    input  logic [31:0] i_IMemRdata_32,
    output logic        o_Valid,
    input  logic        i_Ready,
    output logic [31:0] o_NextPC_32,
    output logic [31:0] o_PCPlus4_32,
    output logic [31:0] o_Instr_32,
    output logic        o_MisalignErr
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_nxt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] occupancy;
    logic [CW:0]   credits_used;
    logic          req_en;
    logic          halted;
    logic          grant;
    logic          accept;
    logic          pop;
    logic          buf_empty;
    logic [63:0]   head;
    logic [31:0]   redirect_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    fetch_state_e state;
    logic         misalign;

    assign redirect_pc = i_RedirectPC_32;
    assign misalign    = i_Redirect && (i_RedirectPC_32[1:0] != 2'b00);
    assign halted      = (state == HALT);

    // HALT is terminal: only reset leaves it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= FETCH;
            o_MisalignErr <= 1'b0;
        end else if (state == FETCH && misalign) begin
            state         <= HALT;
            o_MisalignErr <= 1'b1;
        end
    end
`else
    logic unused_redirect_lsb;

    assign redirect_pc         = {i_RedirectPC_32[31:2], 2'b00};
    assign unused_redirect_lsb = ^i_RedirectPC_32[1:0];
    assign halted              = 1'b0;
    assign o_MisalignErr       = 1'b0;
`endif

    // Credits are counted from registered state only, so a pop this cycle
    // does not open a slot until the following cycle.
    assign credits_used  = (CW+1)'(inflight) + (CW+1)'(occupancy);
    assign o_IMemReq     = req_en && !halted && !i_Redirect &&
                           (credits_used < (CW+1)'(BUF_DEPTH));
    assign o_IMemAddr_32 = fetch_pc;
    assign grant         = o_IMemReq && i_IMemGnt;

    assign inflight_nxt  = inflight + CW'(grant) - CW'(i_IMemRspValid);

    // A response is kept only outside a redirect cycle and once every
    // response older than the last redirect has been dropped.
    assign accept = i_IMemRspValid && !i_Redirect && !halted && (drop_cnt == '0);

    assign o_Valid      = !buf_empty && !i_Redirect && !halted;
    assign pop          = o_Valid && i_Ready;
    assign o_NextPC_32  = head[63:32];
    assign o_Instr_32   = head[31:0];
    assign o_PCPlus4_32 = pc_plus4(head[63:32]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            req_en   <= 1'b0;
        end else begin
            req_en   <= 1'b1;
            inflight <= inflight_nxt;
            if (i_Redirect) begin
                fetch_pc <= redirect_pc;
                rsp_pc   <= redirect_pc;
                drop_cnt <= inflight_nxt;
            end else begin
                if (grant) begin
                    fetch_pc <= pc_plus4(fetch_pc);
                end
                if (i_IMemRspValid && drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end else if (accept) begin
                    rsp_pc <= pc_plus4(rsp_pc);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH     (BUF_DEPTH),
        .RST_ENTRY ({RESET_PC, 32'h0})
    ) u_fetch_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (i_Redirect),
        .push      (accept),
        .push_data ({rsp_pc, i_IMemRdata_32}),
        .pop       (pop),
        .head_data (head),
        .empty     (buf_empty),
        .count     (occupancy)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit -- directed bench for if_fetch_unit.
// The memory model grants whenever gnt_en is set and answers each granted
// address one cycle later, in order, with data ~addr (held off by rsp_hold).

module tb_if_fetch_unit;

    logic        clk;
    logic        rstn;
    logic        i_Redirect;
    logic [31:0] i_RedirectPC_32;
    logic        o_IMemReq;
    logic [31:0] o_IMemAddr_32;
    logic        i_IMemGnt;
    logic        i_IMemRspValid;
    logic [31:0] i_IMemRdata_32;
    logic        o_Valid;
    logic        i_Ready;
    logic [31:0] o_NextPC_32;
    logic [31:0] o_PCPlus4_32;
    logic [31:0] o_Instr_32;
    logic        o_MisalignErr;

    logic [31:0] mem_q[$];
    logic [31:0] req_log[$];
    logic [31:0] out_pc[$];
    logic [31:0] out_p4[$];
    logic [31:0] out_in[$];
    logic        rsp_hold;
    logic        gnt_en;
    int          n_vec;
    int          n_err;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk             (clk),
        .rstn            (rstn),
        .i_Redirect      (i_Redirect),
        .i_RedirectPC_32 (i_RedirectPC_32),
        .o_IMemReq       (o_IMemReq),
        .o_IMemAddr_32   (o_IMemAddr_32),
        .i_IMemGnt       (i_IMemGnt),
        .i_IMemRspValid  (i_IMemRspValid),
        .i_IMemRdata_32  (i_IMemRdata_32),
        .o_Valid         (o_Valid),
        .i_Ready         (i_Ready),
        .o_NextPC_32     (o_NextPC_32),
        .o_PCPlus4_32    (o_PCPlus4_32),
        .o_Instr_32      (o_Instr_32),
        .o_MisalignErr   (o_MisalignErr)
    );

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input int idx, input logic [31:0] exp);
        if (idx < req_log.size()) chk(tag, req_log[idx], exp);
        else chk({tag, "_missing"}, 32'(req_log.size()), 32'(idx + 1));
    endtask

    task automatic chk_out(input string tag, input int idx, input logic [31:0] exp_pc);
        if (idx < out_pc.size()) begin
            chk({tag, "_pc"}, out_pc[idx], exp_pc);
            chk({tag, "_pc4"}, out_p4[idx], exp_pc + 32'd4);
            chk({tag, "_instr"}, out_in[idx], ~exp_pc);
        end else begin
            chk({tag, "_missing"}, 32'(out_pc.size()), 32'(idx + 1));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        req_log.delete();
        out_pc.delete();
        out_p4.delete();
        out_in.delete();
    endtask

    // Present this cycle's memory inputs and let outputs settle.
    task automatic begin_cycle();
        logic [31:0] a;
        if (!rsp_hold && mem_q.size() > 0) begin
            a = mem_q.pop_front();
            i_IMemRspValid = 1'b1;
            i_IMemRdata_32 = ~a;
        end else begin
            i_IMemRspValid = 1'b0;
            i_IMemRdata_32 = 32'h0;
        end
        i_IMemGnt = gnt_en;
        #2;
    endtask

    // Record transfers seen this cycle, then advance past the clock edge.
    task automatic end_cycle();
        #1;
        if (o_IMemReq && i_IMemGnt) begin
            mem_q.push_back(o_IMemAddr_32);
            req_log.push_back(o_IMemAddr_32);
        end
        if (o_Valid && i_Ready) begin
            out_pc.push_back(o_NextPC_32);
            out_p4.push_back(o_PCPlus4_32);
            out_in.push_back(o_Instr_32);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            begin_cycle();
            end_cycle();
        end
    endtask

    task automatic apply_reset();
        rstn            = 1'b0;
        i_Redirect      = 1'b0;
        i_RedirectPC_32 = 32'h0;
        i_Ready         = 1'b1;
        i_IMemGnt       = 1'b0;
        i_IMemRspValid  = 1'b0;
        i_IMemRdata_32  = 32'h0;
        rsp_hold        = 1'b0;
        gnt_en          = 1'b1;
        mem_q.delete();
        #1;
        chk("rst_req", 32'(o_IMemReq), 32'd0);
        chk("rst_valid", 32'(o_Valid), 32'd0);
        chk("rst_err", 32'(o_MisalignErr), 32'd0);
        chk("rst_pc", o_NextPC_32, 32'h0);
        chk("rst_pc4", o_PCPlus4_32, 32'h4);
        chk("rst_instr", o_Instr_32, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        clear_logs();
    endtask

    task automatic redirect_cycle(input logic [31:0] target);
        begin_cycle();
        i_Redirect      = 1'b1;
        i_RedirectPC_32 = target;
        #1;
        chk("redir_req_low", 32'(o_IMemReq), 32'd0);
        clear_logs();
        end_cycle();
        i_Redirect = 1'b0;
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        logic saw_req;
        logic found;
        n_vec = 0;
        n_err = 0;
        rstn  = 1'b1;
        #1;

        // Sequential fetch; address held while not granted.
        apply_reset();
        gnt_en  = 1'b0;
        saw_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            begin_cycle();
            if (o_IMemReq) begin
                saw_req = 1'b1;
                chk("addr_hold", o_IMemAddr_32, 32'h0);
            end
            end_cycle();
        end
        chk("req_seen", 32'(saw_req), 32'd1);
        gnt_en = 1'b1;
        run(12);
        chk_req("seq_req0", 0, 32'h0);
        chk_req("seq_req1", 1, 32'h4);
        chk_req("seq_req2", 2, 32'h8);
        chk_out("seq_out0", 0, 32'h0);
        chk_out("seq_out1", 1, 32'h4);
        chk_out("seq_out2", 2, 32'h8);

        // Backpressure: credit limit, head held, in-order drain.
        apply_reset();
        i_Ready = 1'b0;
        run(10);
        chk("bp_req_count", 32'(req_log.size()), 32'd2);
        chk("bp_valid", 32'(o_Valid), 32'd1);
        chk("bp_head_pc", o_NextPC_32, 32'h0);
        i_Ready = 1'b1;
        run(12);
        chk_out("bp_out0", 0, 32'h0);
        chk_out("bp_out1", 1, 32'h4);
        chk_out("bp_out2", 2, 32'h8);
        chk_out("bp_out3", 3, 32'hC);

        // Redirect with two requests in flight.
        apply_reset();
        rsp_hold = 1'b1;
        run(5);
        chk("inflight_reqs", 32'(req_log.size()), 32'd2);
        redirect_cycle(32'h100);
        rsp_hold = 1'b0;
        run(12);
        chk_req("drop_req0", 0, 32'h100);
        chk_out("drop_out0", 0, 32'h100);
        chk_out("drop_out1", 1, 32'h104);

        // Redirect in a cycle with a grant and a response.
        apply_reset();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            begin_cycle();
            if (i_IMemRspValid && o_IMemReq) begin
                i_Redirect      = 1'b1;
                i_RedirectPC_32 = 32'h200;
                #1;
                chk("same_req_low", 32'(o_IMemReq), 32'd0);
                chk("same_valid_low", 32'(o_Valid), 32'd0);
                clear_logs();
                found = 1'b1;
            end
            end_cycle();
            i_Redirect = 1'b0;
        end
        chk("same_window_found", 32'(found), 32'd1);
        run(12);
        chk_req("same_req0", 0, 32'h200);
        chk_out("same_out0", 0, 32'h200);

        // Redirect while the buffer holds entries: o_Valid masked.
        apply_reset();
        i_Ready = 1'b0;
        run(8);
        begin_cycle();
        chk("full_valid_pre", 32'(o_Valid), 32'd1);
        i_Redirect      = 1'b1;
        i_RedirectPC_32 = 32'h300;
        #1;
        chk("full_valid_redir", 32'(o_Valid), 32'd0);
        clear_logs();
        end_cycle();
        i_Redirect = 1'b0;
        i_Ready    = 1'b1;
        run(12);
        chk_out("full_out0", 0, 32'h300);

        // PC wrap at the top of the address space.
        apply_reset();
        redirect_cycle(32'hFFFF_FFF8);
        run(15);
        chk_req("wrap_req0", 0, 32'hFFFF_FFF8);
        chk_req("wrap_req1", 1, 32'hFFFF_FFFC);
        chk_req("wrap_req2", 2, 32'h0);
        chk_out("wrap_out0", 0, 32'hFFFF_FFF8);
        chk_out("wrap_out1", 1, 32'hFFFF_FFFC);
        chk_out("wrap_out2", 2, 32'h0);

        // Misaligned redirect target.
        apply_reset();
        run(3);
        redirect_cycle(32'h102);
        run(12);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_err", 32'(o_MisalignErr), 32'd1);
        chk("mis_req_count", 32'(req_log.size()), 32'd0);
        chk("mis_out_count", 32'(out_pc.size()), 32'd0);
        chk("mis_valid", 32'(o_Valid), 32'd0);
`else
        chk("mis_err", 32'(o_MisalignErr), 32'd0);
        chk_req("mis_req0", 0, 32'h100);
        chk_out("mis_out0", 0, 32'h100);
`endif

        // Reset in the middle of outstanding requests.
        apply_reset();
        rsp_hold = 1'b1;
        run(5);
        apply_reset();
        run(12);
        chk_req("mid_rst_req0", 0, 32'h0);
        chk_out("mid_rst_out0", 0, 32'h0);
        chk_out("mid_rst_out1", 1, 32'h4);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rstn.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC fetched first after reset.
REQ-003 Parameter BUF_DEPTH, default 2: fetch buffer entries and maximum in-flight plus buffered fetches.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 i_Redirect  input  1  branch/jump redirect from a later stage.
REQ-007 i_RedirectPC_32  input  32  redirect target.
REQ-008 o_IMemReq  output  1  instruction-memory read request.
REQ-009 o_IMemAddr_32  output  32  request address.
REQ-010 i_IMemGnt  input  1  request accepted this cycle.
REQ-011 i_IMemRspValid  input  1  in-order read data valid.
REQ-012 i_IMemRdata_32  input  32  instruction word.
REQ-013 o_Valid  output  1  buffer head valid toward the IF/DE register.
REQ-014 i_Ready  input  1  IF/DE register accepts the head.
REQ-015 o_NextPC_32  output  32  PC of head instruction.
REQ-016 o_PCPlus4_32  output  32  head PC + 4.
REQ-017 o_Instr_32  output  32  head instruction.
REQ-018 o_MisalignErr  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-019 The fetch PC register SHALL advance by 4 on each grant (o_IMemReq && i_IMemGnt), modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-020 The block SHALL assert o_IMemReq only when in-flight count + buffer occupancy < BUF_DEPTH, not halted, and i_Redirect low; a pop in the same cycle SHALL NOT free a credit.
REQ-021 o_IMemAddr_32 SHALL equal the fetch PC and SHALL remain stable while o_IMemReq is high without grant.
REQ-022 On i_Redirect, the fetch PC and the response PC SHALL load i_RedirectPC_32, and the buffer SHALL flush at that edge.
REQ-023 On i_Redirect, the drop counter SHALL load the in-flight count after that cycle's grant and response, so all older responses are discarded.
REQ-024 A response with drop counter > 0 SHALL decrement the counter and be discarded; otherwise {response PC, rdata} SHALL be pushed and the response PC SHALL advance by 4.
REQ-025 A response arriving in the redirect cycle SHALL be discarded.
REQ-026 o_Valid SHALL equal buffer not-empty AND NOT i_Redirect; a pop SHALL occur on o_Valid && i_Ready.
REQ-027 Push and pop in the same cycle SHALL keep occupancy unchanged; the buffer SHALL never overflow, guaranteed by credit (REQ-020).
REQ-028 Latency: redirect at edge N gives o_IMemReq with the target in cycle N+1; o_Valid rises one cycle after the accepted response (no bypass).
REQ-029 o_PCPlus4_32 SHALL equal o_NextPC_32 + 4, modulo 2^32.

Reset
REQ-030 While rstn is low: fetch PC = response PC = RESET_PC; in-flight = drop = occupancy = 0; o_IMemReq = 0; o_Valid = 0; o_MisalignErr = 0; o_NextPC_32 = RESET_PC; o_PCPlus4_32 = RESET_PC + 4; o_Instr_32 = 0.
REQ-031 Reset asserted mid-transaction SHALL abandon all in-flight requests; the memory is also reset and returns no stale responses.

Configuration
REQ-032 With FETCH_MISALIGN_CHECK_EN defined: a redirect with target[1:0] != 0 SHALL set o_MisalignErr, enter state HALT (no requests, buffer flushed), and hold until reset; the only states are FETCH and HALT.
REQ-033 Without FETCH_MISALIGN_CHECK_EN: target[1:0] SHALL be forced to 0, o_MisalignErr SHALL be tied to 0, and there SHALL be no HALT state.

Structure
REQ-034 The shared package rv32i_pkg SHALL hold the defaults for RESET_PC and BUF_DEPTH, the instruction width of 32, and the PC increment of 4.
REQ-035 The buffer SHALL be a sub-module fetch_fifo (parameterized depth, 64-bit {pc, instr} entries, synchronous flush input).

Verification
REQ-036 Reset release, memory latency 1, i_Ready = 1 -> requests 0x0, 0x4, 0x8; outputs PC 0x0/0x4/0x8 with o_PCPlus4_32 0x4/0x8/0xC.
REQ-037 i_Ready = 0 for 10 cycles -> at most 2 requests issued, occupancy 2, o_Valid held with PC 0x0; on release, in-order drain.
REQ-038 Two in flight, redirect to 0x100 -> both old responses dropped, next request 0x100, first o_Valid carries PC 0x100.
REQ-039 Redirect in the same cycle as a grant and a response -> both discarded, o_Valid low in the redirect cycle, next output PC equals the target.
REQ-040 Redirect to 0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; o_PCPlus4_32 for 0xFFFF_FFFC is 0x0.
REQ-041 With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> o_MisalignErr = 1, no further o_IMemReq, o_Valid = 0 until reset; without the macro -> fetch at 0x100.
